// File: rtl/ecc_mont_result_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module : ecc_mont_result_sink_pkg
// Brief  : Shared definitions for the Montgomery result sink: state encoding,
//          datapath width defaults and the word-count derivation.
// Rev    : 1.0 - initial release
// ============================================================================
package ecc_mont_result_sink_pkg;

    localparam int c_RADIX_DEFAULT    = 32;
    localparam int c_REG_SIZE_DEFAULT = 384;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

    function automatic int words_of(input int reg_size, input int radix);
        return reg_size / radix;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_word_sub_borrow.sv
`default_nettype none
// ============================================================================
// Module : ecc_word_sub_borrow
// Brief  : Combinational RADIX-bit subtract a - b - borrow_in with borrow out.
// Rev    : 1.0 - initial release
// ============================================================================
module ecc_word_sub_borrow #(
    parameter int RADIX = 32
) (
    input  logic [RADIX-1:0] a,
    input  logic [RADIX-1:0] b,
    input  logic             borrow_in,
    output logic [RADIX-1:0] diff,
    output logic             borrow_out
);

    logic [RADIX:0] w_wide;

    // The extra top bit of the zero-extended difference is the borrow.
    assign w_wide     = {1'b0, a} - {1'b0, b} - {{RADIX{1'b0}}, borrow_in};
    assign diff       = w_wide[RADIX-1:0];
    assign borrow_out = w_wide[RADIX];

endmodule
`default_nettype wire

// File: rtl/ecc_mont_result_sink.sv
`default_nettype none
// ============================================================================
// Module : ecc_mont_result_sink
// Brief  : Drains the LSW-first result stream of the Montgomery array, applies
//          the final conditional subtraction of p and presents the result.
// Rev    : 1.0 - initial release
// ============================================================================
module ecc_mont_result_sink
    import ecc_mont_result_sink_pkg::*;
#(
    parameter int RADIX    = c_RADIX_DEFAULT,
    parameter int REG_SIZE = c_REG_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_in,
    input  logic                word_valid_in,
    input  logic [RADIX-1:0]    t_in,
    input  logic                t_msb_in,
    input  logic [REG_SIZE-1:0] p_in,
    output logic [REG_SIZE-1:0] res_out,
    output logic                ready_out,
    output logic                busy_out
);

    localparam int WORDS = words_of(REG_SIZE, RADIX);
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WORDS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_borrow;
    logic [REG_SIZE-1:0] r_t_buf;
    logic [REG_SIZE-1:0] r_d_buf;
    logic [REG_SIZE-1:0] r_res;

    logic [RADIX-1:0]    w_p_word;
    logic [RADIX-1:0]    w_d_word;
    logic                w_borrow_out;
    logic                w_accept;
    logic                w_last;
    logic                w_sel_sub;
    logic [REG_SIZE-1:0] w_t_full;
    logic [REG_SIZE-1:0] w_d_full;

    // start_in has priority, so a word arriving with it is dropped.
    assign w_accept = (r_state == ST_COLLECT) && word_valid_in && !start_in;
    assign w_last   = w_accept && (r_cnt == c_LAST_IDX);
    assign w_p_word = p_in[r_cnt*RADIX +: RADIX];

    ecc_word_sub_borrow #(
        .RADIX (RADIX)
    ) u_sub (
        .a          (t_in),
        .b          (w_p_word),
        .borrow_in  (r_borrow),
        .diff       (w_d_word),
        .borrow_out (w_borrow_out)
    );

    // Buffers with the current word merged in, so the final select can be
    // registered on the same edge that stores the last word.
    always_comb begin
        w_t_full = r_t_buf;
        w_d_full = r_d_buf;
        w_t_full[r_cnt*RADIX +: RADIX] = t_in;
        w_d_full[r_cnt*RADIX +: RADIX] = w_d_word;
    end

    // T >= p exactly when T has a carry-out or the full subtraction did not borrow.
    assign w_sel_sub = t_msb_in | ~w_borrow_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start_in) begin
            w_state_next = ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: if (w_last) w_state_next = ST_DONE;
                ST_DONE:    w_state_next = ST_DONE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        busy_out  = (r_state == ST_COLLECT);
        ready_out = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_t_buf  <= '0;
            r_d_buf  <= '0;
            r_res    <= '0;
        end else if (start_in) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_t_buf  <= w_t_full;
            r_d_buf  <= w_d_full;
            r_borrow <= w_borrow_out;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_res <= w_sel_sub ? w_d_full : w_t_full;
            end
        end
    end

    assign res_out = r_res;

endmodule
`default_nettype wire

// File: tb/tb_ecc_mont_result_sink.sv
`default_nettype none
// ============================================================================
// Module : tb_ecc_mont_result_sink
// Brief  : Scoreboard bench for ecc_mont_result_sink with RADIX=32, REG_SIZE=64.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ecc_mont_result_sink;

    localparam int RADIX    = 32;
    localparam int REG_SIZE = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                start_in;
    logic                word_valid_in;
    logic [RADIX-1:0]    t_in;
    logic                t_msb_in;
    logic [REG_SIZE-1:0] p_in;
    logic [REG_SIZE-1:0] res_out;
    logic                ready_out;
    logic                busy_out;

    int n_vec = 0;
    int n_err = 0;
    logic [REG_SIZE-1:0] exp_q[$];
    logic prev_ready = 1'b0;

    always #5 clk = ~clk;

    ecc_mont_result_sink #(
        .RADIX    (RADIX),
        .REG_SIZE (REG_SIZE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_in      (start_in),
        .word_valid_in (word_valid_in),
        .t_in          (t_in),
        .t_msb_in      (t_msb_in),
        .p_in          (p_in),
        .res_out       (res_out),
        .ready_out     (ready_out),
        .busy_out      (busy_out)
    );

    task automatic check(input string name, input logic [REG_SIZE-1:0] act,
                         input logic [REG_SIZE-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // All tasks start and end on a falling edge; inputs change there.
    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic send_word(input logic [RADIX-1:0] w, input logic msb);
        word_valid_in = 1'b1;
        t_in          = w;
        t_msb_in      = msb;
        @(negedge clk);
        word_valid_in = 1'b0;
        t_msb_in      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Two-word operation; expected result queued before the last word.
    task automatic run_op(input string name, input logic [REG_SIZE-1:0] p,
                          input logic [REG_SIZE-1:0] t, input logic msb,
                          input logic [REG_SIZE-1:0] req);
        p_in = p;
        pulse_start();
        check({name, "_busy"}, {63'd0, busy_out}, 64'd1);
        send_word(t[31:0], 1'b0);
        check({name, "_rdy_early"}, {63'd0, ready_out}, 64'd0);
        exp_q.push_back(req);
        send_word(t[63:32], msb);
        check({name, "_rdy"}, {63'd0, ready_out}, 64'd1);
        check({name, "_busy_end"}, {63'd0, busy_out}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start_in = 1'b0; word_valid_in = 1'b0;
        t_in = '0; t_msb_in = 1'b0; p_in = '0;

        // Scoreboard monitor: pops on every rising ready_out.
        fork
            forever begin
                @(negedge clk);
                if (ready_out && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL mon_unexpected: got %h, expected no result", res_out);
                    end else begin
                        check("mon_res", res_out, exp_q.pop_front());
                    end
                end
                prev_ready = ready_out;
            end
        join_none

        idle(3);
        check("rst_res", res_out, 64'd0);
        check("rst_ready", {63'd0, ready_out}, 64'd0);
        check("rst_busy", {63'd0, busy_out}, 64'd0);
        reset = 1'b0;
        idle(1);

        run_op("nosub", 64'h0000000000000007, 64'h0000000000000005, 1'b0,
               64'h0000000000000005);
        send_word(32'hDEADBEEF, 1'b1);
        check("done_ignore_res", res_out, 64'h0000000000000005);
        check("done_ignore_rdy", {63'd0, ready_out}, 64'd1);

        run_op("xborrow", 64'h0000000100000007, 64'h0000000200000003, 1'b0,
               64'h00000000FFFFFFFC);
        run_op("eq", 64'h0000000100000007, 64'h0000000100000007, 1'b0,
               64'h0000000000000000);
        run_op("msb", 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000003, 1'b1,
               64'h0000000000000004);

        // Gapped stream
        p_in = 64'h7;
        pulse_start();
        send_word(32'h5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("gap_busy", {63'd0, busy_out}, 64'd1);
            idle(1);
        end
        exp_q.push_back(64'h5);
        send_word(32'h0, 1'b0);
        check("gap_rdy", {63'd0, ready_out}, 64'd1);

        // Abort mid-stream and restart
        p_in = 64'h7;
        pulse_start();
        send_word(32'h12345678, 1'b1);
        pulse_start();
        check("abort_busy", {63'd0, busy_out}, 64'd1);
        send_word(32'h9, 1'b0);
        exp_q.push_back(64'h2);
        send_word(32'h0, 1'b0);
        check("abort_rdy", {63'd0, ready_out}, 64'd1);

        // Reset mid-collect, then words without a start
        pulse_start();
        send_word(32'h1, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send_word(32'h5, 1'b0);
        send_word(32'h0, 1'b0);
        idle(2);
        check("rstmid_rdy", {63'd0, ready_out}, 64'd0);
        check("rstmid_busy", {63'd0, busy_out}, 64'd0);
        check("rstmid_res", res_out, 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
